// File: rtl/alu_pkg.sv
// Shared ALU control-code constants and legality check, imported by the ALU
// and by every block that drives it.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    function automatic logic is_legal_alu_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_XOR,
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU, ALU_NOP: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_rsp_slot.sv
// Single-entry response register with valid/ready; a load and a drain in the
// same cycle keep the slot full so a port can complete one op per cycle.
module alu_rsp_slot #(
    parameter int XLEN = 64,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] load_data,
    input  logic [TAGW-1:0] load_tag,
    input  logic            load_err,
    input  logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] data,
    output logic [TAGW-1:0] tag,
    output logic            err,
    output logic            free
);

    assign free = !valid || ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            tag   <= '0;
            err   <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            tag   <= load_tag;
            err   <= load_err;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the execute pipeline
// (port 0) and the address/branch-compare unit (port 1).
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [XLEN-1:0] req_a0,
    input  logic [XLEN-1:0] req_a1,
    input  logic [XLEN-1:0] req_b0,
    input  logic [XLEN-1:0] req_b1,
    input  logic [3:0]      req_op0,
    input  logic [3:0]      req_op1,
    input  logic [TAGW-1:0] req_tag0,
    input  logic [TAGW-1:0] req_tag1,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_result,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [XLEN-1:0] rsp_data0,
    output logic [XLEN-1:0] rsp_data1,
    output logic [TAGW-1:0] rsp_tag0,
    output logic [TAGW-1:0] rsp_tag1,
    output logic [1:0]      rsp_err
);

    logic [1:0]      slot_free;
    logic [1:0]      eligible;
    logic [1:0]      grant;
    logic            last_grant;
    logic            op_legal;
    logic [XLEN-1:0] load_data;

    assign eligible = req_valid & slot_free;

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_NOP;
        if (grant[0]) begin
            alu_a    = req_a0;
            alu_b    = req_b0;
            alu_ctrl = req_op0;
        end else if (grant[1]) begin
            alu_a    = req_a1;
            alu_b    = req_b1;
            alu_ctrl = req_op1;
        end
    end

    // Illegal codes still reach the ALU; the result is replaced by zero here.
    assign op_legal  = is_legal_alu_op(alu_ctrl);
    assign load_data = op_legal ? alu_result : '0;

    // Idle cycles leave the pointer alone so a skipped port keeps its turn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

    alu_rsp_slot #(.XLEN(XLEN), .TAGW(TAGW)) u_slot0 (
        .clk       (clk),
        .reset     (reset),
        .load      (grant[0]),
        .load_data (load_data),
        .load_tag  (req_tag0),
        .load_err  (!op_legal),
        .ready     (rsp_ready[0]),
        .valid     (rsp_valid[0]),
        .data      (rsp_data0),
        .tag       (rsp_tag0),
        .err       (rsp_err[0]),
        .free      (slot_free[0])
    );

    alu_rsp_slot #(.XLEN(XLEN), .TAGW(TAGW)) u_slot1 (
        .clk       (clk),
        .reset     (reset),
        .load      (grant[1]),
        .load_data (load_data),
        .load_tag  (req_tag1),
        .load_err  (!op_legal),
        .ready     (rsp_ready[1]),
        .valid     (rsp_valid[1]),
        .data      (rsp_data1),
        .tag       (rsp_tag1),
        .err       (rsp_err[1]),
        .free      (slot_free[1])
    );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized bench for alu_share_arbiter against a behavioural
// model of the arbitration, ALU and response-slot rules.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a0, req_a1, req_b0, req_b1;
    logic [3:0]  req_op0, req_op1;
    logic [3:0]  req_tag0, req_tag1;
    logic [63:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_data0, rsp_data1;
    logic [3:0]  rsp_tag0, rsp_tag1;
    logic [1:0]  rsp_err;

    logic [63:0] ina   [2];
    logic [63:0] inb   [2];
    logic [3:0]  inop  [2];
    logic [3:0]  intag [2];

    assign req_a0 = ina[0];   assign req_a1 = ina[1];
    assign req_b0 = inb[0];   assign req_b1 = inb[1];
    assign req_op0 = inop[0]; assign req_op1 = inop[1];
    assign req_tag0 = intag[0]; assign req_tag1 = intag[1];

    // Reference model state
    logic        m_valid [2];
    logic [63:0] m_data  [2];
    logic [3:0]  m_tag   [2];
    logic        m_err   [2];
    int          m_last;
    logic        held    [2];

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] LEGAL_OPS [11] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7,
                                              4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF};

    always #5 clk = ~clk;

    alu_share_arbiter #(.XLEN(64), .TAGW(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1), .req_tag0(req_tag0), .req_tag1(req_tag1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rsp_tag0(rsp_tag0), .rsp_tag1(rsp_tag1), .rsp_err(rsp_err)
    );

    function automatic logic legal(input logic [3:0] op);
        for (int k = 0; k < 11; k++)
            if (LEGAL_OPS[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
        logic signed [63:0] sa;
        sa = a;
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h6: return a - b;
            4'h7: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'h8: return a ^ b;
            4'h9: return a << b[5:0];
            4'hA: return a >> b[5:0];
            4'hB: return sa >>> b[5:0];
            4'hC: return (a < b) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    // Shared ALU stand-in; illegal codes yield junk that must never reach a slot.
    always_comb alu_result = legal(alu_ctrl) ? alu_ref(alu_a, alu_b, alu_ctrl)
                                             : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0; m_data[i] = '0; m_tag[i] = '0; m_err[i] = 1'b0;
        end
        m_last = 1;
    endtask

    // One clock: compare at the falling edge, advance the model, return at posedge+1.
    task automatic step();
        logic [1:0]  elig, exp_g;
        logic [63:0] ea, eb;
        logic [3:0]  ec;
        @(negedge clk);
        for (int i = 0; i < 2; i++)
            elig[i] = req_valid[i] && (!m_valid[i] || rsp_ready[i]);
        if (elig == 2'b11) exp_g = (m_last == 1) ? 2'b01 : 2'b10;
        else               exp_g = elig;
        ea = '0; eb = '0; ec = 4'hF;
        for (int i = 0; i < 2; i++)
            if (exp_g[i]) begin ea = ina[i]; eb = inb[i]; ec = inop[i]; end
        check("req_ready", 64'(req_ready), 64'(exp_g));
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_ctrl", 64'(alu_ctrl), 64'(ec));
        check("rsp_valid", 64'(rsp_valid), 64'({m_valid[1], m_valid[0]}));
        check("rsp_data0", rsp_data0, m_data[0]);
        check("rsp_data1", rsp_data1, m_data[1]);
        check("rsp_tag0", 64'(rsp_tag0), 64'(m_tag[0]));
        check("rsp_tag1", 64'(rsp_tag1), 64'(m_tag[1]));
        for (int i = 0; i < 2; i++)
            if (m_valid[i]) check($sformatf("rsp_err%0d", i), 64'(rsp_err[i]), 64'(m_err[i]));
        for (int i = 0; i < 2; i++) begin
            if (exp_g[i]) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = intag[i];
                m_err[i]   = !legal(inop[i]);
                m_data[i]  = legal(inop[i]) ? alu_ref(ina[i], inb[i], inop[i]) : 64'd0;
            end else if (m_valid[i] && rsp_ready[i]) begin
                m_valid[i] = 1'b0;
            end
            held[i] = req_valid[i] && !exp_g[i];
        end
        if (exp_g != 2'b00) m_last = exp_g[1] ? 1 : 0;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] op, input logic [3:0] tg);
        ina[p] = a; inb[p] = b; inop[p] = op; intag[p] = tg;
    endtask

    initial begin
        logic [3:0] op;
        reset = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        set_req(0, 0, 0, 4'h0, 0);
        set_req(1, 0, 0, 4'h0, 0);
        held[0] = 1'b0; held[1] = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        check("reset_rsp_data0", rsp_data0, 64'd0);
        check("reset_alu_ctrl", 64'(alu_ctrl), 64'hF);
        @(posedge clk); #1;
        reset = 1'b0;

        // ADD 5+7 on port 0, response one cycle later
        req_valid = 2'b01;
        set_req(0, 64'd5, 64'd7, 4'b0010, 4'd3);
        step();
        req_valid = 2'b00;
        check("add_rsp_data0", rsp_data0, 64'd12);
        check("add_rsp_tag0", 64'(rsp_tag0), 64'd3);
        step();

        // Continuous contention with both slots draining: alternation
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        set_req(0, 64'd100, 64'd1, 4'b0110, 4'd1);
        set_req(1, 64'hF0, 64'h0F, 4'b0001, 4'd2);
        repeat (4) step();

        // Port 0 slot full and undrained: port 1 takes every grant
        rsp_ready = 2'b10;
        repeat (3) step();
        rsp_ready = 2'b11;
        repeat (3) step();

        // Illegal op on port 1, then SUB 1-2
        req_valid = 2'b10;
        set_req(1, 64'd9, 64'd9, 4'b0011, 4'd5);
        step();
        set_req(1, 64'd1, 64'd2, 4'b0110, 4'd6);
        check("illegal_err1", 64'(rsp_err[1]), 64'd1);
        check("illegal_data1", rsp_data1, 64'd0);
        step();
        req_valid = 2'b00;
        check("sub_data1", rsp_data1, 64'hFFFF_FFFF_FFFF_FFFF);
        step();

        // Back-to-back XOR on port 0, then an idle cycle
        rsp_ready = 2'b01;
        req_valid = 2'b01;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 64'(k * 3 + 1), 64'h55, 4'b1000, 4'(k));
            step();
        end
        req_valid = 2'b00;
        step();

        // Fill both slots, then reset mid-operation
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        set_req(0, 64'd3, 64'd4, 4'b0010, 4'd7);
        set_req(1, 64'd8, 64'd2, 4'b1001, 4'd8);
        repeat (3) step();
        check("pre_reset_valid", 64'(rsp_valid), 64'd3);
        reset = 1'b1;
        #1;
        check("async_reset_valid", 64'(rsp_valid), 64'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 2'b11;
        step();
        step();

        // Randomized traffic honouring the hold-while-not-ready contract
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!held[i]) begin
                    req_valid[i] = ($urandom_range(9) < 7);
                    if ($urandom_range(7) == 0) begin
                        op = 4'($urandom_range(15));
                        while (legal(op)) op = 4'($urandom_range(15));
                    end else begin
                        op = LEGAL_OPS[$urandom_range(10)];
                    end
                    set_req(i, {$urandom, $urandom},
                            ($urandom_range(1) == 1) ? 64'($urandom_range(70)) : {$urandom, $urandom},
                            op, 4'($urandom_range(15)));
                end
                rsp_ready[i] = ($urandom_range(9) < 6);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
